gol_gen_sequencer: RTL
======================

# gol_gen_sequencer

Generation sequencer for the Game of Life board: it owns the double-buffered cell array and steps it one generation per `tick` while the game FSM reports RUN. It sits between the game FSM (consumes its 2-bit `game_state`) and the display/LED driver (drives the flattened `board`). It accepts single-cell programming writes in PROGRAM. It scans the grid one cell per clock, applies B3/S23 rules with toroidal wrap, and swaps banks atomically at the end of each generation.

## Interface
- `ROWS`, 8, grid rows
- `COLS`, 16, grid columns; `CELLS = ROWS*COLS` (128), index width 7
- `clka`  in  1  system clock; all state updates on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `game_state`  in  2  FSM state: 00 IDLE, 01 PROGRAM, 10 RUN, 11 PAUSE
- `tick`  in  1  generation-step strobe; sampled every cycle
- `prog_wr`  in  1  cell write strobe; honoured only in PROGRAM
- `prog_idx`  in  7  cell index for `prog_wr` (row*COLS+col)
- `prog_val`  in  1  value written to the cell
- `board`  out  CELLS  current generation, bit i = cell i
- `cell_idx`  out  7  cell being evaluated; 0 when not scanning
- `busy`  out  1  high during SCAN and COMMIT
- `gen_done`  out  1  one-cycle pulse on bank swap
- `gen_count`  out  16  generations completed since last IDLE
- `overrun`  out  1  sticky: a tick arrived while busy

## Operation
- Storage: two CELLS-bit banks A/B plus `act_sel`; `board` is always the active bank.
- Sequencer states: S_IDLE, S_SCAN, S_COMMIT.
- S_IDLE: `busy`=0, `cell_idx`=0. Go to S_SCAN when `tick`=1 and `game_state`=RUN; `cell_idx` is loaded with 0.
- S_SCAN: for cell `cell_idx` (row=idx/COLS, col=idx%COLS), sum the 8 neighbours from the active bank. Neighbour row/col wrap modulo ROWS/COLS (row 0's upper neighbour is row ROWS-1; col COLS-1's right neighbour is col 0). The sum is 4 bits, range 0..8.
- Next value = (sum==3) | (alive & sum==2), written to the same index in the inactive bank. `cell_idx` increments. After idx CELLS-1, go to S_COMMIT.
- S_COMMIT: toggle `act_sel`, increment `gen_count` (wraps FFFF→0000), pulse `gen_done`, return to S_IDLE.
- PROGRAM, when not busy: `prog_wr` writes `prog_val` to `prog_idx` in the active bank. Writes with `prog_idx` ≥ CELLS are ignored. `prog_wr` is ignored in all other game states.
- PAUSE: new ticks do not start a scan. A scan already in progress runs to COMMIT, so generations are atomic.
- IDLE (`game_state`=00): this is the abort path and acts like a clear.
  - The sequencer is forced to S_IDLE, any scan in progress is discarded, and no swap occurs.
  - Both banks, `act_sel`, `gen_count` and `overrun` are cleared.
- Overrun: `tick`=1 while `busy`=1 sets `overrun`. The tick is dropped, not queued.

## Timing
- Reset (`rst_n`=0 at an edge) values:
  - `board`=0, both banks 0, `act_sel`=0
  - `cell_idx`=0, `busy`=0, `gen_done`=0, `gen_count`=0, `overrun`=0
  - sequencer in S_IDLE
- Reset mid-scan behaves identically to reset at any other time.
- Tick accepted at edge E0:
  - from E0: `busy`=1, `cell_idx`=0
  - edges E1..E128: evaluate cells 0..127
  - after E128: S_COMMIT
  - at E129: bank swap, new `board`, `gen_count`+1, `gen_done`=1 for exactly one cycle, `busy`=0
- Tick-to-board latency is CELLS+1 edges. Minimum tick spacing without overrun is CELLS+2 cycles.
- A tick coincident with the COMMIT edge counts as overrun (`busy` is still 1).
- A prog write takes effect at the sampling edge and is visible on `board` in the next cycle.
- `game_state`=IDLE and `tick` in the same cycle: IDLE wins and no scan starts.
- `game_state` leaves RUN for PAUSE or PROGRAM mid-scan: the scan completes.
- Programming is only honoured when not busy. A `prog_wr` in PROGRAM during a completing scan is dropped.

## Test plan
- Reset then idle: hold `rst_n`=0 for 2 cycles, release with `game_state`=IDLE, `tick`=1 → `board`=0, `busy`=0, `gen_count`=0, `overrun`=0.
- Blinker: in PROGRAM set idx 52,53,54. Switch to RUN and pulse `tick`.
  - After 129 edges: `gen_done` pulse, `board` bits set = {37,53,69}, `gen_count`=1.
  - A second tick → {52,53,54}, `gen_count`=2.
- Toroidal wrap: program idx 0,1,2 (row 0 blinker) and tick → bits {1,17,113} set, all others 0.
- Overrun and pause:
  - Tick, then tick again 10 cycles later → `overrun`=1, only one generation completes.
  - Switch to PAUSE at cycle 50 of a scan → scan completes, swap at edge 129, later ticks ignored while paused.
- Abort: set `game_state`=IDLE at cycle 60 of a scan → next cycle `busy`=0, `board`=0, `gen_count`=0, `overrun`=0, no `gen_done` pulse.
- Program filtering:
  - `prog_wr` with `prog_idx`=127/`prog_val`=1 in RUN → ignored.
  - Same write in PROGRAM → bit 127 set the next cycle.

Source files
------------

// File: rtl/gol_gen_sequencer.sv
// gol_gen_sequencer
//
// Steps a toroidal Game of Life board (B3/S23) one generation per accepted
// tick. The board lives in two banks: the active bank drives `board`, and the
// scan writes the next generation into the inactive bank one cell per clock.
// Swapping the banks happens only in the commit cycle, so the displayed board
// always changes a whole generation at a time.
//
// Ports:
//   clka        system clock, all state changes on the rising edge
//   rst_n       synchronous active-low reset
//   game_state  00 IDLE (clears everything), 01 PROGRAM, 10 RUN, 11 PAUSE
//   tick        generation-step strobe, starts a scan in RUN when idle
//   prog_wr     single-cell write strobe, honoured in PROGRAM when not busy
//   prog_idx    cell index for prog_wr (row*COLS+col)
//   prog_val    value written by prog_wr
//   board       active bank, bit i = cell i
//   cell_idx    cell currently being evaluated, 0 when not scanning
//   busy        high while scanning or committing
//   gen_done    one-cycle pulse in the cycle after the bank swap
//   gen_count   generations completed since the last IDLE
//   overrun     sticky, set by a tick that arrives while busy
module gol_gen_sequencer #(
  parameter int ROWS  = 8,
  parameter int COLS  = 16,
  parameter int CELLS = ROWS * COLS,
  parameter int IDX_W = $clog2(CELLS)
) (
  input  logic             clka,
  input  logic             rst_n,
  input  logic [1:0]       game_state,
  input  logic             tick,
  input  logic             prog_wr,
  input  logic [IDX_W-1:0] prog_idx,
  input  logic             prog_val,
  output logic [CELLS-1:0] board,
  output logic [IDX_W-1:0] cell_idx,
  output logic             busy,
  output logic             gen_done,
  output logic [15:0]      gen_count,
  output logic             overrun
);

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [1:0] GS_IDLE    = 2'b00;
  localparam logic [1:0] GS_PROGRAM = 2'b01;
  localparam logic [1:0] GS_RUN     = 2'b10;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(CELLS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(COLS - 1);
  localparam logic [IDX_W:0]   CELLS_EXT = (IDX_W + 1)'(CELLS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_COMMIT
  } seq_state_t;

  seq_state_t       state_reg;
  logic [CELLS-1:0] bank_a_reg;
  logic [CELLS-1:0] bank_b_reg;
  logic             act_sel_reg;
  logic [IDX_W-1:0] cell_idx_reg;
  // Row/column tracked alongside cell_idx so no divider is needed.
  logic [ROW_W-1:0] row_reg;
  logic [COL_W-1:0] col_reg;
  logic             busy_reg;
  logic             gen_done_reg;
  logic [15:0]      gen_count_reg;
  logic             overrun_reg;

  logic [CELLS-1:0] active_bank;
  logic [ROW_W-1:0] nb_row [3];
  logic [COL_W-1:0] nb_col [3];
  logic [8:0]       nbr;
  logic [3:0]       nbr_sum;
  logic             next_val;
  logic             prog_in_range;

  assign active_bank = act_sel_reg ? bank_b_reg : bank_a_reg;

  // Neighbour coordinates with toroidal wrap: index 0 = above/left,
  // 1 = same, 2 = below/right.
  assign nb_row[0] = (row_reg == '0) ? LAST_ROW : row_reg - 1'b1;
  assign nb_row[1] = row_reg;
  assign nb_row[2] = (row_reg == LAST_ROW) ? '0 : row_reg + 1'b1;
  assign nb_col[0] = (col_reg == '0) ? LAST_COL : col_reg - 1'b1;
  assign nb_col[1] = col_reg;
  assign nb_col[2] = (col_reg == LAST_COL) ? '0 : col_reg + 1'b1;

  // 3x3 window around the current cell; nbr[4] is the cell itself.
  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_nbr
      assign nbr[gi] = active_bank[IDX_W'(nb_row[gi / 3]) * IDX_W'(COLS)
                                   + IDX_W'(nb_col[gi % 3])];
    end
  endgenerate

  always_comb begin
    nbr_sum = '0;
    for (int i = 0; i < 9; i++) begin
      if (i != 4) begin
        nbr_sum = nbr_sum + {3'b000, nbr[i]};
      end
    end
  end

  assign next_val      = (nbr_sum == 4'd3) | (nbr[4] & (nbr_sum == 4'd2));
  assign prog_in_range = ({1'b0, prog_idx} < CELLS_EXT);

  always_ff @(posedge clka) begin
    // IDLE is the abort path: it discards any scan and clears like a reset.
    if (!rst_n || game_state == GS_IDLE) begin
      state_reg     <= S_IDLE;
      bank_a_reg    <= '0;
      bank_b_reg    <= '0;
      act_sel_reg   <= 1'b0;
      cell_idx_reg  <= '0;
      row_reg       <= '0;
      col_reg       <= '0;
      busy_reg      <= 1'b0;
      gen_done_reg  <= 1'b0;
      gen_count_reg <= '0;
      overrun_reg   <= 1'b0;
    end else begin
      gen_done_reg <= 1'b0;
      // A tick while busy is dropped, only remembered as an overrun.
      if (tick && busy_reg) begin
        overrun_reg <= 1'b1;
      end
      case (state_reg)
        S_IDLE: begin
          if (tick && game_state == GS_RUN) begin
            state_reg    <= S_SCAN;
            busy_reg     <= 1'b1;
            cell_idx_reg <= '0;
            row_reg      <= '0;
            col_reg      <= '0;
          end else if (prog_wr && game_state == GS_PROGRAM && prog_in_range) begin
            if (act_sel_reg) begin
              bank_b_reg[prog_idx] <= prog_val;
            end else begin
              bank_a_reg[prog_idx] <= prog_val;
            end
          end
        end
        S_SCAN: begin
          // Next generation goes to the inactive bank; display is untouched.
          if (act_sel_reg) begin
            bank_a_reg[cell_idx_reg] <= next_val;
          end else begin
            bank_b_reg[cell_idx_reg] <= next_val;
          end
          if (cell_idx_reg == LAST_IDX) begin
            state_reg    <= S_COMMIT;
            cell_idx_reg <= '0;
            row_reg      <= '0;
            col_reg      <= '0;
          end else begin
            cell_idx_reg <= cell_idx_reg + 1'b1;
            if (col_reg == LAST_COL) begin
              col_reg <= '0;
              row_reg <= row_reg + 1'b1;
            end else begin
              col_reg <= col_reg + 1'b1;
            end
          end
        end
        S_COMMIT: begin
          act_sel_reg   <= ~act_sel_reg;
          gen_count_reg <= gen_count_reg + 1'b1;
          gen_done_reg  <= 1'b1;
          busy_reg      <= 1'b0;
          state_reg     <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign board     = active_bank;
  assign cell_idx  = cell_idx_reg;
  assign busy      = busy_reg;
  assign gen_done  = gen_done_reg;
  assign gen_count = gen_count_reg;
  assign overrun   = overrun_reg;

endmodule
